// File: rtl/digital_clk_set_ctrl.sv
// Time-set controller: captures live time into shadow registers, lets the user
// edit hour/minute/second with wrap-around, then strobes the clock's load input.
module digital_clk_set_ctrl #(
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 30000,
    parameter int BLINK_HALF  = 250
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       mode_btn_i,
    input  logic       inc_btn_i,
    input  logic       dec_btn_i,
    input  logic [4:0] cur_hour_i,
    input  logic [5:0] cur_min_i,
    input  logic [5:0] cur_sec_i,
    output logic [4:0] hour_set_o,
    output logic [5:0] min_set_o,
    output logic [5:0] sec_set_o,
    output logic       load_n_o,
    output logic [2:0] state_o,
    output logic       blink_o
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_SET_HOUR = 3'd1,
        S_SET_MIN  = 3'd2,
        S_SET_SEC  = 3'd3,
        S_LOAD     = 3'd4
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT);
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam int LD_W = 4;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(LOAD_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic [BL_W-1:0]   bl_cnt_reg, bl_cnt_next;
    logic [LD_W-1:0]   ld_cnt_reg, ld_cnt_next;
    logic              blink_reg, blink_next;
    logic              load_n_reg, load_n_next;

    logic [5:0]        shadow_reg  [3];
    logic [5:0]        shadow_next [3];
    logic [5:0]        cur_val     [3];
    logic [2:0]        sel_en;
    logic              capture;
    logic              edit_inc;
    logic              edit_dec;

    assign cur_val[0] = {1'b0, cur_hour_i};
    assign cur_val[1] = cur_min_i;
    assign cur_val[2] = cur_sec_i;

    assign capture  = (state_reg == S_RUN) && mode_btn_i;
    // Mode always wins; simultaneous inc+dec cancels the edit.
    assign edit_inc = inc_btn_i && !dec_btn_i && !mode_btn_i;
    assign edit_dec = dec_btn_i && !inc_btn_i && !mode_btn_i;

    assign sel_en = {state_reg == S_SET_SEC, state_reg == S_SET_MIN, state_reg == S_SET_HOUR};

    // Index 0 is hour (0..23), 1 and 2 are minute/second (0..59).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_field
            localparam logic [5:0] MAX_V = (gi == 0) ? 6'd23 : 6'd59;

            assign shadow_next[gi] =
                capture                   ? ((cur_val[gi] > MAX_V) ? MAX_V : cur_val[gi]) :
                (sel_en[gi] && edit_inc)  ? ((shadow_reg[gi] == MAX_V) ? 6'd0 : shadow_reg[gi] + 6'd1) :
                (sel_en[gi] && edit_dec)  ? ((shadow_reg[gi] == 6'd0) ? MAX_V : shadow_reg[gi] - 6'd1) :
                                            shadow_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        to_cnt_next = to_cnt_reg;
        bl_cnt_next = bl_cnt_reg;
        ld_cnt_next = ld_cnt_reg;
        blink_next  = blink_reg;
        load_n_next = 1'b1;

        case (state_reg)
            S_RUN: begin
                blink_next  = 1'b0;
                bl_cnt_next = '0;
                if (mode_btn_i) begin
                    state_next  = S_SET_HOUR;
                    to_cnt_next = '0;
                    blink_next  = 1'b1;
                end
            end

            S_SET_HOUR, S_SET_MIN, S_SET_SEC: begin
                if (mode_btn_i) begin
                    to_cnt_next = '0;
                    bl_cnt_next = '0;
                    if (state_reg == S_SET_SEC) begin
                        state_next  = S_LOAD;
                        ld_cnt_next = '0;
                        load_n_next = 1'b0;
                        blink_next  = 1'b0;
                    end else begin
                        state_next = (state_reg == S_SET_HOUR) ? S_SET_MIN : S_SET_SEC;
                        blink_next = 1'b1;
                    end
                end else begin
                    if (bl_cnt_reg == BL_LAST) begin
                        bl_cnt_next = '0;
                        blink_next  = !blink_reg;
                    end else begin
                        bl_cnt_next = bl_cnt_reg + 1'b1;
                    end

                    // Any button activity, even a cancelled inc+dec, keeps the edit alive.
                    if (inc_btn_i || dec_btn_i) begin
                        to_cnt_next = '0;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_next  = S_RUN;
                        blink_next  = 1'b0;
                        bl_cnt_next = '0;
                    end else begin
                        to_cnt_next = to_cnt_reg + 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (ld_cnt_reg == LD_LAST) begin
                    state_next = S_RUN;
                end else begin
                    ld_cnt_next = ld_cnt_reg + 1'b1;
                    load_n_next = 1'b0;
                end
            end

            default: begin
                state_next = S_RUN;
                blink_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg  <= S_RUN;
            to_cnt_reg <= '0;
            bl_cnt_reg <= '0;
            ld_cnt_reg <= '0;
            blink_reg  <= 1'b0;
            load_n_reg <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
            bl_cnt_reg <= bl_cnt_next;
            ld_cnt_reg <= ld_cnt_next;
            blink_reg  <= blink_next;
            load_n_reg <= load_n_next;
            for (int i = 0; i < 3; i++) begin
                shadow_reg[i] <= shadow_next[i];
            end
        end
    end

    assign hour_set_o = shadow_reg[0][4:0];
    assign min_set_o  = shadow_reg[1];
    assign sec_set_o  = shadow_reg[2];
    assign load_n_o   = load_n_reg;
    assign state_o    = state_reg;
    assign blink_o    = blink_reg;

endmodule

// File: tb/tb_digital_clk_set_ctrl.sv
// Bench for digital_clk_set_ctrl: directed scenarios plus random buttons,
// checked every cycle against a behavioural model of the set procedure.
module tb_digital_clk_set_ctrl;

    localparam int LC = 2;
    localparam int TO = 8;
    localparam int BH = 3;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       mode_btn_i = 1'b0;
    logic       inc_btn_i = 1'b0;
    logic       dec_btn_i = 1'b0;
    logic [4:0] cur_hour_i = '0;
    logic [5:0] cur_min_i = '0;
    logic [5:0] cur_sec_i = '0;
    logic [4:0] hour_set_o;
    logic [5:0] min_set_o;
    logic [5:0] sec_set_o;
    logic       load_n_o;
    logic [2:0] state_o;
    logic       blink_o;

    int total = 0;
    int bad = 0;

    digital_clk_set_ctrl #(
        .LOAD_CYCLES(LC),
        .TIMEOUT    (TO),
        .BLINK_HALF (BH)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .mode_btn_i (mode_btn_i),
        .inc_btn_i  (inc_btn_i),
        .dec_btn_i  (dec_btn_i),
        .cur_hour_i (cur_hour_i),
        .cur_min_i  (cur_min_i),
        .cur_sec_i  (cur_sec_i),
        .hour_set_o (hour_set_o),
        .min_set_o  (min_set_o),
        .sec_set_o  (sec_set_o),
        .load_n_o   (load_n_o),
        .state_o    (state_o),
        .blink_o    (blink_o)
    );

    always #5 clk_i = ~clk_i;

    // Minimal stand-in for the clock counter: adopts presets while load/reset is low.
    logic [4:0] clk_h;
    logic [5:0] clk_m, clk_s;
    always @(posedge clk_i) begin
        if (!(load_n_o && reset_i)) begin
            clk_h <= hour_set_o;
            clk_m <= min_set_o;
            clk_s <= sec_set_o;
        end
    end

    // Behavioural model: mode number, field values, idle edges, edges since
    // entering the current SET state, and strobe cycles completed.
    int m_state, m_idle, m_age, m_low;
    int m_f[3];

    function automatic int fmod(input int k);
        return (k == 0) ? 24 : 60;
    endfunction

    task automatic model_reset();
        m_state = 0; m_idle = 0; m_age = 0; m_low = 0;
        m_f[0] = 0; m_f[1] = 0; m_f[2] = 0;
    endtask

    task automatic model_edge(input bit m, input bit i, input bit d);
        int k;
        case (m_state)
            0: if (m) begin
                m_f[0] = (int'(cur_hour_i) > 23) ? 23 : int'(cur_hour_i);
                m_f[1] = (int'(cur_min_i) > 59) ? 59 : int'(cur_min_i);
                m_f[2] = (int'(cur_sec_i) > 59) ? 59 : int'(cur_sec_i);
                m_state = 1; m_idle = 0; m_age = 0;
            end
            1, 2, 3: begin
                k = m_state - 1;
                if (m) begin
                    if (m_state == 3) begin m_state = 4; m_low = 0; end
                    else begin m_state++; m_idle = 0; m_age = 0; end
                end else begin
                    m_age++;
                    if (i || d) begin
                        m_idle = 0;
                        if (i && !d) m_f[k] = (m_f[k] + 1) % fmod(k);
                        else if (d && !i) m_f[k] = (m_f[k] + fmod(k) - 1) % fmod(k);
                    end else begin
                        m_idle++;
                        if (m_idle == TO) m_state = 0;
                    end
                end
            end
            default: begin
                m_low++;
                if (m_low == LC) m_state = 0;
            end
        endcase
    endtask

    function automatic logic [21:0] exp_vec();
        logic bl;
        bl = (m_state >= 1 && m_state <= 3) && ((m_age / BH) % 2 == 0);
        return {3'(m_state), 5'(m_f[0]), 6'(m_f[1]), 6'(m_f[2]), (m_state != 4), bl};
    endfunction

    function automatic logic [21:0] obs();
        return {state_o, hour_set_o, min_set_o, sec_set_o, load_n_o, blink_o};
    endfunction

    // Drives one cycle of buttons; entered and left #1 after a rising edge.
    task automatic step(input bit m, input bit i, input bit d);
        mode_btn_i = m; inc_btn_i = i; dec_btn_i = d;
        @(posedge clk_i);
        model_edge(m, i, d);
        #1;
        mode_btn_i = 1'b0; inc_btn_i = 1'b0; dec_btn_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b1;
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        cur_hour_i = 5'(h); cur_min_i = 6'(mi); cur_sec_i = 6'(s);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs() !== 22'h000002) begin
            bad++; $display("FAIL reset got=%h exp=%h", obs(), 22'h000002);
        end
    endtask

    task automatic test_capture();
        set_time(13, 45, 10);
        step(1, 0, 0);
        total++;
        if (obs() !== exp_vec() || state_o !== 3'd1 || hour_set_o !== 5'd13 || blink_o !== 1'b1) begin
            bad++; $display("FAIL capture got=%h exp=%h", obs(), exp_vec());
        end
        for (int c = 0; c < 2 * BH + 1; c++) begin
            step(0, 0, 0);
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL blink_cycle%0d got=%h exp=%h", c, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_time(23, 0, 59);
        step(1, 0, 0);
        step(0, 1, 0);
        total++;
        if (obs() !== exp_vec() || hour_set_o !== 5'd0 || min_set_o !== 6'd0) begin
            bad++; $display("FAIL hour_wrap got=%h exp=%h", obs(), exp_vec());
        end
        step(1, 0, 0);
        step(0, 0, 1);
        total++;
        if (obs() !== exp_vec() || min_set_o !== 6'd59 || hour_set_o !== 5'd0) begin
            bad++; $display("FAIL min_wrap got=%h exp=%h", obs(), exp_vec());
        end
        step(1, 0, 0);
        step(0, 1, 0);
        total++;
        if (obs() !== exp_vec() || sec_set_o !== 6'd0 || min_set_o !== 6'd59) begin
            bad++; $display("FAIL sec_wrap got=%h exp=%h", obs(), exp_vec());
        end
    endtask

    task automatic move_field(input int k, input int target);
        for (int n = 0; n < 60 && m_f[k] != target; n++) begin
            step(0, m_f[k] < target, m_f[k] > target);
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL edit_f%0d got=%h exp=%h", k, obs(), exp_vec());
            end
            step(0, 0, 0);
        end
    endtask

    task automatic test_full_load();
        int lows;
        do_reset();
        set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        step(1, 0, 0);
        move_field(0, 7);
        step(1, 0, 0);
        move_field(1, 30);
        step(1, 0, 0);
        move_field(2, 0);
        step(1, 0, 0);
        total++;
        if (obs() !== exp_vec() || state_o !== 3'd4 || load_n_o !== 1'b0) begin
            bad++; $display("FAIL load_entry got=%h exp=%h", obs(), exp_vec());
        end
        lows = 1;
        for (int c = 0; c < 4; c++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            if (load_n_o === 1'b0) lows++;
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL load_cycle%0d got=%h exp=%h", c, obs(), exp_vec());
            end
        end
        total++;
        if (lows !== LC) begin
            bad++; $display("FAIL load_width got=%0d exp=%0d", lows, LC);
        end
        total++;
        if ({clk_h, clk_m, clk_s} !== {5'd7, 6'd30, 6'd0}) begin
            bad++; $display("FAIL clock_time got=%0d:%0d:%0d exp=7:30:0", clk_h, clk_m, clk_s);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_time(5, 20, 40);
        step(1, 0, 0);
        step(1, 1, 0);
        total++;
        if (obs() !== exp_vec() || state_o !== 3'd2 || hour_set_o !== 5'd5) begin
            bad++; $display("FAIL mode_inc got=%h exp=%h", obs(), exp_vec());
        end
        repeat (5) step(0, 0, 0);
        step(0, 1, 1);
        total++;
        if (obs() !== exp_vec() || min_set_o !== 6'd20) begin
            bad++; $display("FAIL inc_dec got=%h exp=%h", obs(), exp_vec());
        end
        for (int c = 0; c < TO; c++) begin
            step(0, 0, 0);
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL inc_dec_idle%0d got=%h exp=%h", c, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        bit went_low;
        do_reset();
        set_time(9, 15, 33);
        step(1, 0, 0);
        step(1, 0, 0);
        went_low = 1'b0;
        for (int c = 0; c < TO; c++) begin
            step(0, 0, 0);
            if (load_n_o !== 1'b1) went_low = 1'b1;
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL timeout_cycle%0d got=%h exp=%h", c, obs(), exp_vec());
            end
        end
        total++;
        if (state_o !== 3'd0 || went_low) begin
            bad++; $display("FAIL timeout_end got state=%0d low=%0d exp state=0 low=0", state_o, went_low);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        set_time($urandom_range(24, 31), $urandom_range(60, 63), $urandom_range(60, 63));
        step(1, 0, 0);
        total++;
        if (obs() !== exp_vec() || {hour_set_o, min_set_o, sec_set_o} !== {5'd23, 6'd59, 6'd59}) begin
            bad++; $display("FAIL clamp got=%h exp=%h", obs(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        set_time(11, 22, 33);
        repeat (4) step(1, 0, 0);
        total++;
        if (load_n_o !== 1'b0) begin
            bad++; $display("FAIL pre_reset_load got=%b exp=0", load_n_o);
        end
        reset_i = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs() !== exp_vec()) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", obs(), exp_vec());
        end
        @(posedge clk_i);
        #1 reset_i = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0)
                set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL random_cycle%0d got=%h exp=%h", c, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_capture();
        test_wrap();
        test_full_load();
        test_simultaneous();
        test_timeout();
        test_clamp();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digital_clk_set_ctrl.md
# digital_clk_set_ctrl

Time-set controller for the 24-hour digital clock. It turns three debounced one-cycle button pulses (mode, increment, decrement) into a sequenced set procedure: capture current time, edit hour/minute/second in shadow registers, then strobe the clock's active-low load/reset input so the clock adopts the edited values. It sits between the board button conditioners and the clock counter. It drives the clock's hour/minute/second preset inputs and its load strobe, and supplies a blink enable for the display.

## Interface

Parameters:
- LOAD_CYCLES, 2: width in clk_i cycles of the load_n_o low strobe (1..15).
- TIMEOUT, 30000: idle cycles in any SET state before the edit is abandoned (≥2).
- BLINK_HALF, 250: clk_i cycles per blink_o half-period (≥1).

Ports:
- clk_i  in  1  system clock, same clock as the clock counter.
- reset_i  in  1  asynchronous, active-low reset.
- mode_btn_i  in  1  one-cycle pulse: enter / advance set mode.
- inc_btn_i  in  1  one-cycle pulse: increment selected field.
- dec_btn_i  in  1  one-cycle pulse: decrement selected field.
- cur_hour_i  in  5  live clock hour, 0..23.
- cur_min_i  in  6  live clock minute, 0..59.
- cur_sec_i  in  6  live clock second, 0..59.
- hour_set_o  out  5  hour preset to the clock.
- min_set_o  out  6  minute preset to the clock.
- sec_set_o  out  6  second preset to the clock.
- load_n_o  out  1  active-low load strobe. Integration ANDs it with reset_i into the clock's reset input.
- state_o  out  3  RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, LOAD=4.
- blink_o  out  1  display blink for the selected field; 0 in RUN and LOAD.

## Operation

- Reset (async, reset_i=0): state RUN, hour/min/sec_set_o=0, load_n_o=1, blink_o=0, timeout and blink counters 0.
- RUN: mode_btn_i moves to SET_HOUR and latches cur_* into the shadows on the same edge. inc/dec are ignored. Shadows hold otherwise.
- SET_HOUR / SET_MIN / SET_SEC edit their own field:
  - inc adds 1 with wrap: hour 23→0, min/sec 59→0.
  - dec subtracts 1 with wrap: hour 0→23, min/sec 0→59.
  - Other fields are untouched.
- Button precedence:
  - mode plus inc/dec in the same cycle: mode wins and the edit is dropped.
  - inc and dec together without mode: no change, but the timeout counter is still cleared.
- Mode advances the state: SET_HOUR→SET_MIN→SET_SEC→LOAD.
- LOAD:
  - load_n_o=0 for exactly LOAD_CYCLES cycles, then the state returns to RUN with load_n_o=1.
  - All buttons are ignored.
  - Shadows are held stable for the whole strobe.
- Timeout:
  - The counter clears on state entry and on any button pulse in a SET state.
  - When it reaches TIMEOUT-1 in a SET state, the next edge goes to RUN with no load strobe and shadows unchanged.
- Blink:
  - In SET states, blink_o toggles every BLINK_HALF cycles, starting at 1 on SET state entry.
  - The blink counter restarts on each SET state entry.
- Shadows never hold out-of-range values. An out-of-range cur_* at capture is clamped: hour >23 →23, min/sec >59 →59.

## Timing

- Every button takes effect on the edge where it is sampled high. state_o and the shadows update one cycle after the pulse.
- Mode in SET_SEC at edge n gives load_n_o=0 from after edge n through edge n+LOAD_CYCLES, and state_o=RUN after edge n+LOAD_CYCLES.
- The preset outputs are registered and stable at least one cycle before load_n_o falls, and throughout the strobe.
- Asserting reset_i mid-LOAD forces load_n_o=1 immediately (asynchronous). The clock is reset by the system reset path anyway.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan

- Reset, then live time 13:45:10; pulse mode → state_o=1, set outputs 13/45/10, blink_o=1, load_n_o=1.
- In SET_HOUR at 23, pulse inc → 0. In SET_MIN at 0, pulse dec → 59. In SET_SEC at 59, pulse inc → 0. Other fields unchanged.
- Full sequence, with LOAD_CYCLES=2:
  - Set 07:30:00.
  - Mode press in SET_SEC → state_o=4; load_n_o low for exactly 2 cycles with presets 7/30/0; then state_o=0.
  - Clock module reads 07:30:00.
- Simultaneous events:
  - mode+inc in SET_HOUR → state_o=2, hour unchanged.
  - inc+dec in SET_MIN → no change, timeout counter cleared.
  - Buttons during LOAD → ignored.
- Timeout with TIMEOUT=8: enter SET_MIN and stay idle 8 cycles → state_o=0, load_n_o never low.
- Reset mid-LOAD (reset_i low during the strobe's first cycle) → load_n_o=1, state_o=0, presets 0, all asynchronous.
